alu_wide_sequencer: RTL and testbench
=====================================

// Module: alu_wide_sequencer
// PURPOSE
//  Runs 32-bit operations on the 16-bit combinational ArithmeticLogicUnit, one ALU pass per clock.
//  Sits directly upstream of the ALU. It drives the ALU's A, B, FunSel and WF inputs and captures ALUOut.
//  Requests arrive on a valid/ready port. Each 32-bit result plus computed flags is returned on a valid/ready port.
//  The ALU's FlagsOut is not used. All carry, borrow and flag logic is computed locally (ADC 10101 is never issued).
// PARAMETERS
//  SKIP_FIX  1  1: FIX pass runs only when needed. 0: FIX pass always runs with a neutral operand (fixed latency).
// PORTS
//  Clock      in   1   rising-edge clock
//  Reset      in   1   asynchronous, active-high reset
//  ReqValid   in   1   request valid
//  ReqReady   out  1   request accepted on an edge where ReqValid and ReqReady are both 1
//  ReqOp      in   3   000 MOVA, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 LSL1, 111 LSR1
//  ReqA       in   32  operand A
//  ReqB       in   32  operand B (ignored by MOVA, LSL1, LSR1)
//  AluA       out  16  to ALU A
//  AluB       out  16  to ALU B
//  AluFunSel  out  5   to ALU FunSel (16-bit codes only, bit 4 = 1)
//  AluWF      out  1   to ALU WF; tied to 0
//  AluOut     in   16  from ALU ALUOut (combinational, same cycle)
//  RspValid   out  1   result valid
//  RspReady   in   1   result consumed on an edge where RspValid and RspReady are both 1
//  RspData    out  32  result
//  RspFlags   out  4   [3] Z, [2] C, [1] N, [0] O (same bit layout as ALU FlagsOut)
// BEHAVIOUR
//  States: IDLE -> LO -> HI -> (FIX) -> DONE -> IDLE. One ALU pass per state. AluOut is registered at the end of each pass state.
//  IDLE: ReqReady=1. AluA=AluB=0, AluFunSel=0. On accept, latch ReqOp, ReqA and ReqB, then go to LO.
//   ReqReady=0 in every other state; ReqValid is ignored there.
//  LO: A=A[15:0], B=B[15:0], FunSel per op. Result goes to lo. fix_needed is computed from the latched operands.
//  HI: A=A[31:16], B=B[31:16], same FunSel. Result goes to hi.
//   Go to FIX if fix_needed or SKIP_FIX=0; otherwise go to DONE.
//  Op FunSel codes: MOVA 10000, ADD 10100, SUB 10110, AND 10111, OR 11000, XOR 11001, LSL1 11011, LSR1 11100.
//  FIX pass (AluA = the target half):
//   ADD: needed when A[15:0]+B[15:0] > 16'hFFFF. FunSel 10100, B=1, target hi.
//   SUB: needed when A[15:0] < B[15:0] (borrow). FunSel 10110, B=1, target hi.
//   LSL1: needed when A[15]=1. FunSel 11000, B=16'h0001, target hi.
//   LSR1: needed when A[16]=1. FunSel 11000, B=16'h8000, target lo.
//   When not needed and SKIP_FIX=0: same pass with B=0 (result unchanged). Logic ops and MOVA use 11000, B=0, target hi.
//  Entry to DONE: RspData={hi,lo} and RspFlags are registered. RspValid=1 is held with data stable until RspReady=1.
//   Then go to IDLE, with RspValid=0 from the next cycle.
//  Latency from the accept edge to RspValid=1: 3 cycles without FIX, 4 cycles with FIX.
//   Minimum request-to-request spacing is 4 or 5 cycles.
//  Flags, where R is the 32-bit result:
//   Z = (R == 0).
//   N = R[31].
//   C: ADD carry out of bit 31; SUB unsigned borrow (A < B); LSL1 A[31]; LSR1 A[0]; all other ops 0.
//   O: ADD (A[31]==B[31] && R[31]!=A[31]); SUB (A[31]!=B[31] && R[31]!=A[31]); all other ops 0.
//  Arithmetic is modulo 2^32. FIX handles carry or borrow wrap in hi (e.g. hi 16'hFFFF + 1 = 16'h0000; C comes from the 33-bit sum).
//  Reset, at any time including mid-operation:
//   state=IDLE; RspValid=0; RspData=0; RspFlags=0; latched operands=0.
//   ReqReady=1 and AluA=AluB=AluFunSel=AluWF=0. Any in-flight operation is dropped.
// TESTING
//  1 ADD 0x0000FFFF+0x00000001 -> RspData 0x00010000, flags 0000, RspValid 4 cycles after accept (FIX taken).
//  2 SUB 0x00000000-0x00000001 -> 0xFFFFFFFF, flags 0110 (C=1 borrow, N=1). ADD 0x7FFFFFFF+1 -> 0x80000000, flags 0011.
//  3 ADD 0xFFFFFFFF+0x00000001 -> 0x00000000, flags 1100. AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000, flags 0010, latency 3 cycles.
//  4 LSL1 0x80008000 -> 0x00010000, C=1. LSR1 0x00010001 -> 0x00008000, C=1.
//    SKIP_FIX=0 build: every op takes 4 cycles with identical results.
//  5 RspReady held 0 for 5 cycles -> RspValid, RspData and RspFlags stable, ReqReady=0, toggling ReqValid ignored.
//    After RspReady=1: IDLE next cycle, ReqReady=1.
//  6 Reset pulsed while in HI -> RspValid=0 immediately, ReqReady=1 after release, no response for the dropped op.
//    A following XOR 0xFFFF0000^0x0F0F0F0F returns 0xF0F00F0F, flags 0010.

Source files
------------

// File: rtl/alu_wide_sequencer_if.sv
// Request, response and ALU-side signal bundle for alu_wide_sequencer.
// The slave modport is the sequencer; the master modport is its environment (requester, consumer, ALU).
interface alu_wide_sequencer_if;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  ReqOp;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [15:0] AluOut;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspData;
    logic [3:0]  RspFlags;

    modport slave (
        input  ReqValid, ReqOp, ReqA, ReqB, AluOut, RspReady,
        output ReqReady, AluA, AluB, AluFunSel, AluWF, RspValid, RspData, RspFlags
    );

    modport master (
        output ReqValid, ReqOp, ReqA, ReqB, AluOut, RspReady,
        input  ReqReady, AluA, AluB, AluFunSel, AluWF, RspValid, RspData, RspFlags
    );
endinterface

// File: rtl/alu_wide_sequencer.sv
// Runs 32-bit operations as two or three passes through an external 16-bit combinational ALU.
// Carry, borrow and all result flags are derived locally; the ALU's own flags are never used.
module alu_wide_sequencer #(
    parameter bit SKIP_FIX = 1'b1
) (
    input logic                Clock,
    input logic                Reset,
    alu_wide_sequencer_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_MOVA = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_AND  = 3'b011,
        OP_OR   = 3'b100, OP_XOR = 3'b101, OP_LSL1 = 3'b110, OP_LSR1 = 3'b111
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [15:0] lo_q, lo_d, hi_q, hi_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;

    logic        fix_needed, fix_lo_target;
    logic [4:0]  op_fs, fix_fs;
    logic [15:0] fix_b;
    logic        req_ready;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_fs;
    logic [31:0] result;
    logic        carry32, flag_c, flag_o;

    // Carry tests use a > ~b, equivalent to a + b overflowing the operand width.
    always_comb begin
        op_fs         = '0;
        fix_fs        = 5'b11000;
        fix_b         = '0;
        fix_needed    = 1'b0;
        fix_lo_target = 1'b0;
        case (op_q)
            OP_MOVA: op_fs = 5'b10000;
            OP_ADD: begin
                op_fs      = 5'b10100;
                fix_fs     = 5'b10100;
                fix_b      = 16'h0001;
                fix_needed = a_q[15:0] > ~b_q[15:0];
            end
            OP_SUB: begin
                op_fs      = 5'b10110;
                fix_fs     = 5'b10110;
                fix_b      = 16'h0001;
                fix_needed = a_q[15:0] < b_q[15:0];
            end
            OP_AND:  op_fs = 5'b10111;
            OP_OR:   op_fs = 5'b11000;
            OP_XOR:  op_fs = 5'b11001;
            OP_LSL1: begin
                op_fs      = 5'b11011;
                fix_b      = 16'h0001;
                fix_needed = a_q[15];
            end
            OP_LSR1: begin
                op_fs         = 5'b11100;
                fix_b         = 16'h8000;
                fix_needed    = a_q[16];
                fix_lo_target = 1'b1;
            end
            default: op_fs = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.ReqValid) state_d = S_LO;
            S_LO:   state_d = S_HI;
            S_HI:   state_d = (fix_needed || !SKIP_FIX) ? S_FIX : S_DONE;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (bus.RspReady) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_fs    = '0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_LO: begin
                alu_a  = a_q[15:0];
                alu_b  = b_q[15:0];
                alu_fs = op_fs;
            end
            S_HI: begin
                alu_a  = a_q[31:16];
                alu_b  = b_q[31:16];
                alu_fs = op_fs;
            end
            S_FIX: begin
                alu_a  = fix_lo_target ? lo_q : hi_q;
                alu_b  = fix_needed ? fix_b : '0;
                alu_fs = fix_fs;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign bus.ReqReady  = req_ready;
    assign bus.AluA      = alu_a;
    assign bus.AluB      = alu_b;
    assign bus.AluFunSel = alu_fs;
    assign bus.AluWF     = 1'b0;
    assign bus.RspValid  = (state_q == S_DONE);
    assign bus.RspData   = rsp_data_q;
    assign bus.RspFlags  = rsp_flags_q;

    assign carry32 = a_q > ~b_q;

    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        result      = {bus.AluOut, lo_q};
        flag_c      = 1'b0;
        flag_o      = 1'b0;
        case (state_q)
            S_IDLE: if (bus.ReqValid) begin
                op_d = op_t'(bus.ReqOp);
                a_d  = bus.ReqA;
                b_d  = bus.ReqB;
            end
            S_LO: lo_d = bus.AluOut;
            S_HI: hi_d = bus.AluOut;
            S_FIX: begin
                if (fix_lo_target) begin
                    lo_d   = bus.AluOut;
                    result = {hi_q, bus.AluOut};
                end else begin
                    hi_d = bus.AluOut;
                end
            end
            default: result = {bus.AluOut, lo_q};
        endcase
        case (op_q)
            OP_ADD: begin
                flag_c = carry32;
                flag_o = (a_q[31] == b_q[31]) && (result[31] != a_q[31]);
            end
            OP_SUB: begin
                flag_c = a_q < b_q;
                flag_o = (a_q[31] != b_q[31]) && (result[31] != a_q[31]);
            end
            OP_LSL1: flag_c = a_q[31];
            OP_LSR1: flag_c = a_q[0];
            default: flag_c = 1'b0;
        endcase
        // The last pass result is captured straight from AluOut on the edge that enters DONE.
        if (state_d == S_DONE && state_q != S_DONE) begin
            rsp_data_d  = result;
            rsp_flags_d = {result == 32'h0, flag_c, result[31], flag_o};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            op_q        <= OP_MOVA;
            a_q         <= '0;
            b_q         <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer: models the 16-bit ALU, drives requests against a
// 32-bit reference model through a scoreboard, for both SKIP_FIX=1 and SKIP_FIX=0 builds.
module tb_alu_wide_sequencer;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    alu_wide_sequencer_if if0();
    alu_wide_sequencer_if if1();

    alu_wide_sequencer #(.SKIP_FIX(1'b1)) dut0 (.Clock(Clock), .Reset(Reset), .bus(if0));
    alu_wide_sequencer #(.SKIP_FIX(1'b0)) dut1 (.Clock(Clock), .Reset(Reset), .bus(if1));

    function automatic logic [15:0] alu16(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b);
        case (fs)
            5'b10000: return a;
            5'b10100: return a + b;
            5'b10110: return a - b;
            5'b10111: return a & b;
            5'b11000: return a | b;
            5'b11001: return a ^ b;
            5'b11011: return a << 1;
            5'b11100: return a >> 1;
            default:  return 16'h0000;
        endcase
    endfunction

    assign if0.AluOut = alu16(if0.AluFunSel, if0.AluA, if0.AluB);
    assign if1.AluOut = alu16(if1.AluFunSel, if1.AluA, if1.AluB);

    // sel picks which instance the request/response tasks talk to
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;

    assign if0.ReqValid = req_valid & ~sel;
    assign if1.ReqValid = req_valid & sel;
    assign if0.RspReady = rsp_ready & ~sel;
    assign if1.RspReady = rsp_ready & sel;
    assign if0.ReqOp = req_op;
    assign if1.ReqOp = req_op;
    assign if0.ReqA  = req_a;
    assign if1.ReqA  = req_a;
    assign if0.ReqB  = req_b;
    assign if1.ReqB  = req_b;

    wire        req_ready_w = sel ? if1.ReqReady : if0.ReqReady;
    wire        rsp_valid_w = sel ? if1.RspValid : if0.RspValid;
    wire [31:0] rsp_data_w  = sel ? if1.RspData  : if0.RspData;
    wire [3:0]  rsp_flags_w = sel ? if1.RspFlags : if0.RspFlags;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        int unsigned lat;
    } exp_t;
    exp_t sb[$];

    int tests_run = 0;
    int failures  = 0;

    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [3:0] f, output bit fix);
        logic [32:0] s;
        logic c, o;
        c = 1'b0; o = 1'b0; fix = 1'b0; r = '0;
        case (op)
            3'b000: r = a;
            3'b001: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                o = (a[31] == b[31]) && (r[31] != a[31]);
                fix = ({1'b0, a[15:0]} + {1'b0, b[15:0]}) > 17'h0FFFF;
            end
            3'b010: begin
                r = a - b;
                c = a < b;
                o = (a[31] != b[31]) && (r[31] != a[31]);
                fix = a[15:0] < b[15:0];
            end
            3'b011: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: begin r = a << 1; c = a[31]; fix = a[15]; end
            3'b111: begin r = a >> 1; c = a[0];  fix = a[16]; end
            default: r = '0;
        endcase
        f = {r == 32'h0, c, r[31], o};
    endfunction

    task automatic send_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit fix;
        bit ready_seen;
        ref_model(op, a, b, e.data, e.flags, fix);
        e.lat = (fix || sel) ? 4 : 3;
        sb.push_back(e);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_w) begin ready_seen = 1'b1; break; end
            @(posedge Clock); #1;
        end
        if (!ready_seen) begin
            tests_run++; failures++;
            $display("FAIL req_ready_timeout: got ReqReady=0 for 20 cycles, expected 1");
        end
        @(posedge Clock); #1;
        req_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; the accept cycle counts as cycle 1.
    task automatic wait_rsp(input bit ack, output logic [31:0] d, output logic [3:0] f,
                            output int unsigned lat, output bit got);
        lat = 1; got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clock); #1;
            lat++;
            if (rsp_valid_w) begin got = 1'b1; break; end
        end
        d = rsp_data_w;
        f = rsp_flags_w;
        if (got && ack) begin
            rsp_ready = 1'b1;
            @(posedge Clock); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b0; rsp_ready = 1'b0; Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        tests_run++; if (if0.RspValid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", if0.RspValid); end
        tests_run++; if (if0.ReqReady !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b expected 1", if0.ReqReady); end
        tests_run++; if (if0.RspData !== 32'h0) begin failures++; $display("FAIL reset_rsp_data: got %h expected 00000000", if0.RspData); end
        tests_run++; if (if0.RspFlags !== 4'h0) begin failures++; $display("FAIL reset_rsp_flags: got %b expected 0000", if0.RspFlags); end
        tests_run++;
        if ({if0.AluA, if0.AluB, if0.AluFunSel, if0.AluWF} !== 38'h0) begin
            failures++;
            $display("FAIL reset_alu_drive: got A=%h B=%h FS=%b WF=%b expected all 0", if0.AluA, if0.AluB, if0.AluFunSel, if0.AluWF);
        end
        Reset = 1'b0;
        @(posedge Clock); #1;
        tests_run++; if (if0.ReqReady !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready: got %b expected 1", if0.ReqReady); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops[8] = '{3'b001, 3'b010, 3'b001, 3'b001, 3'b011, 3'b110, 3'b111, 3'b000};
        logic [31:0] as[8]  = '{32'h0000FFFF, 32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                                32'hF0F0F0F0, 32'h80008000, 32'h00010001, 32'h12345678};
        logic [31:0] bs[8]  = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                                32'hFF00FF00, 32'h00000000, 32'h00000000, 32'hDEADBEEF};
        logic [31:0] d; logic [3:0] f; int unsigned lat; bit got; exp_t e;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_req(ops[i], as[i], bs[i]);
            wait_rsp(1'b1, d, f, lat, got);
            e = sb.pop_front();
            tests_run++; if (!got) begin failures++; $display("FAIL directed[%0d] rsp_timeout: got no RspValid, expected one", i); end
            tests_run++; if (d !== e.data) begin failures++; $display("FAIL directed[%0d] data: got %h expected %h", i, d, e.data); end
            tests_run++; if (f !== e.flags) begin failures++; $display("FAIL directed[%0d] flags: got %b expected %b", i, f, e.flags); end
            tests_run++; if (lat !== e.lat) begin failures++; $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [3:0] f; int unsigned lat; bit got; exp_t e;
        sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_req(3'($urandom_range(0, 7)), $urandom, $urandom);
            wait_rsp(1'b1, d, f, lat, got);
            e = sb.pop_front();
            tests_run++; if (!got) begin failures++; $display("FAIL b2b[%0d] rsp_timeout: got no RspValid, expected one", i); end
            tests_run++; if (d !== e.data || f !== e.flags) begin failures++; $display("FAIL b2b[%0d] result: got %h/%b expected %h/%b", i, d, f, e.data, e.flags); end
            tests_run++; if (lat !== e.lat) begin failures++; $display("FAIL b2b[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
            tests_run++; if (if0.ReqReady !== 1'b1) begin failures++; $display("FAIL b2b[%0d] idle_ready: got %b expected 1", i, if0.ReqReady); end
        end
    endtask

    task automatic test_fixed_latency();
        logic [2:0]  ops[6] = '{3'b001, 3'b011, 3'b110, 3'b111, 3'b010, 3'b101};
        logic [31:0] as[6]  = '{32'h00010002, 32'hF0F0F0F0, 32'h00004000, 32'h00020004, 32'h00050005, 32'hFFFF0000};
        logic [31:0] bs[6]  = '{32'h00030004, 32'hFF00FF00, 32'h0, 32'h0, 32'h00010001, 32'h0F0F0F0F};
        logic [31:0] d; logic [3:0] f; int unsigned lat; bit got; exp_t e;
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_req(ops[i], as[i], bs[i]);
            wait_rsp(1'b1, d, f, lat, got);
            e = sb.pop_front();
            tests_run++; if (d !== e.data || f !== e.flags) begin failures++; $display("FAIL fixed[%0d] result: got %h/%b expected %h/%b", i, d, f, e.data, e.flags); end
            tests_run++; if (lat !== e.lat) begin failures++; $display("FAIL fixed[%0d] latency: got %0d expected %0d", i, lat, e.lat); end
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic [3:0] f; int unsigned lat; bit got; exp_t e;
        sel = 1'b0;
        send_req(3'b001, 32'h7FFFFFFF, 32'h00000001);
        wait_rsp(1'b0, d, f, lat, got);
        e = sb.pop_front();
        tests_run++; if (!got || d !== e.data || f !== e.flags) begin failures++; $display("FAIL hold_first: got %b %h/%b expected 1 %h/%b", got, d, f, e.data, e.flags); end
        for (int i = 0; i < 5; i++) begin
            req_valid = ~req_valid; req_op = 3'b101; req_a = $urandom; req_b = $urandom;
            @(posedge Clock); #1;
            tests_run++;
            if (if0.RspValid !== 1'b1 || if0.RspData !== e.data || if0.RspFlags !== e.flags || if0.ReqReady !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: got V=%b D=%h F=%b RR=%b expected 1 %h %b 0", i, if0.RspValid, if0.RspData, if0.RspFlags, if0.ReqReady, e.data, e.flags);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge Clock); #1;
        rsp_ready = 1'b0;
        tests_run++; if (if0.RspValid !== 1'b0 || if0.ReqReady !== 1'b1) begin failures++; $display("FAIL hold_release: got V=%b RR=%b expected 0 1", if0.RspValid, if0.ReqReady); end
        @(posedge Clock); #1;
        tests_run++; if (if0.ReqReady !== 1'b1) begin failures++; $display("FAIL hold_no_accept: got RR=%b expected 1", if0.ReqReady); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d; logic [3:0] f; int unsigned lat; bit got; exp_t e;
        bit seen;
        sel = 1'b0;
        req_op = 3'b001; req_a = 32'h0000FFFF; req_b = 32'h00000001; req_valid = 1'b1;
        @(posedge Clock); #1;
        req_valid = 1'b0;
        @(posedge Clock); #1;
        tests_run++; if (if0.ReqReady !== 1'b0 || if0.AluA !== 16'h0000 || if0.AluFunSel !== 5'b10100) begin
            failures++; $display("FAIL midop_in_hi: got RR=%b A=%h FS=%b expected 0 0000 10100", if0.ReqReady, if0.AluA, if0.AluFunSel);
        end
        Reset = 1'b1;
        #1;
        tests_run++; if (if0.RspValid !== 1'b0 || if0.ReqReady !== 1'b1 || if0.AluFunSel !== 5'b0) begin
            failures++; $display("FAIL midop_reset: got V=%b RR=%b FS=%b expected 0 1 00000", if0.RspValid, if0.ReqReady, if0.AluFunSel);
        end
        @(posedge Clock); #1;
        Reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock); #1;
            if (if0.RspValid) seen = 1'b1;
        end
        tests_run++; if (seen || if0.ReqReady !== 1'b1) begin failures++; $display("FAIL midop_dropped: got RspValid seen=%b RR=%b expected 0 1", seen, if0.ReqReady); end
        send_req(3'b101, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_rsp(1'b1, d, f, lat, got);
        e = sb.pop_front();
        tests_run++; if (!got || d !== e.data || f !== e.flags) begin failures++; $display("FAIL post_reset_xor: got %b %h/%b expected 1 %h/%b", got, d, f, e.data, e.flags); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_fixed_latency();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
